icache_responder: RTL

//   Direct-mapped, read-only instruction cache: the responder side of the fetcher's need_inst/PC request.

---
 rtl/icache_responder_if.sv | 34 +++
 rtl/icache_responder.sv | 112 +++++++++++
 2 files changed

// File: rtl/icache_responder_if.sv
// Bus bundle between the instruction fetcher, the icache and the memory controller.
// The cache uses the slave modport; the environment (fetcher + memory) uses master.
interface icache_responder_if;
  logic        need_inst;
  logic [31:0] pc;
  logic        inst_ready;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport slave (
    input  need_inst,
    input  pc,
    input  mem_ready,
    input  mem_data,
    output inst_ready,
    output inst,
    output mem_req,
    output mem_addr
  );

  modport master (
    output need_inst,
    output pc,
    output mem_ready,
    output mem_data,
    input  inst_ready,
    input  inst,
    input  mem_req,
    input  mem_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: same-cycle hits, blocking line refill
// fetched word-by-word from the memory controller starting at word 0.
module icache_responder #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  icache_responder_if.slave   bus
);

  localparam int LINES     = 1 << INDEX_BITS;
  localparam int WORDS     = 1 << OFFSET_BITS;
  localparam int TAG_BITS  = 30 - INDEX_BITS - OFFSET_BITS;
  localparam int LINE_BITS = 30 - OFFSET_BITS;

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  state_t                      state_q;
  logic [OFFSET_BITS-1:0]      cnt_q;
  logic [LINE_BITS-1:0]        miss_line_q;
  logic                        mem_req_q;
  logic                        valid_q [LINES];
  logic [TAG_BITS-1:0]         tag_q   [LINES];
  logic [31:0]                 data_q  [LINES*WORDS];

  logic [OFFSET_BITS-1:0]      pc_offset;
  logic [INDEX_BITS-1:0]       pc_index;
  logic [TAG_BITS-1:0]         pc_tag;
  logic [INDEX_BITS-1:0]       miss_index;
  logic [TAG_BITS-1:0]         miss_tag;
  logic                        hit;
  logic                        word_fill;
  logic                        last_word;
  logic [1:0]                  unused_pc_bits;

  assign pc_offset  = bus.pc[OFFSET_BITS+1:2];
  assign pc_index   = bus.pc[OFFSET_BITS+INDEX_BITS+1:OFFSET_BITS+2];
  assign pc_tag     = bus.pc[31:OFFSET_BITS+INDEX_BITS+2];
  assign miss_index = miss_line_q[INDEX_BITS-1:0];
  assign miss_tag   = miss_line_q[LINE_BITS-1:INDEX_BITS];
  assign unused_pc_bits = bus.pc[1:0];

  // Lookups only answer from IDLE: no hit-under-miss while a line is being filled.
  assign hit       = (state_q == IDLE) && bus.need_inst &&
                     valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign word_fill = rdy_in && (state_q == REFILL) && bus.mem_ready;
  assign last_word = (cnt_q == {OFFSET_BITS{1'b1}});

  assign bus.inst_ready = hit && rdy_in;
  assign bus.inst       = bus.inst_ready ? data_q[{pc_index, pc_offset}] : 32'h0;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = {miss_line_q, cnt_q, 2'b00};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      miss_line_q <= '0;
      mem_req_q   <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (bus.need_inst && !hit) begin
            miss_line_q <= bus.pc[31:OFFSET_BITS+2];
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            state_q     <= REFILL;
          end
        end
        REFILL: begin
          if (bus.mem_ready) begin
            // The line is invalid from its first new word until the whole line is in.
            if (cnt_q == '0) begin
              valid_q[miss_index] <= 1'b0;
            end
            if (last_word) begin
              valid_q[miss_index] <= 1'b1;
              mem_req_q           <= 1'b0;
              cnt_q               <= '0;
              state_q             <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Payload arrays need no reset: nothing reads them while the line is invalid.
  always_ff @(posedge clk_in) begin
    if (word_fill) begin
      data_q[{miss_index, cnt_q}] <= bus.mem_data;
      if (last_word) begin
        tag_q[miss_index] <= miss_tag;
      end
    end
  end

endmodule
